// File: rtl/axis_vip_packer.sv
// Frames captured DUT response vectors into AXI-Stream packets: header, N payload beats, optional trailer.
// Optional XOR trailer beat is enabled by defining AXIS_VIP_PACKER_CHECKSUM_EN.
module axis_vip_packer #(
    parameter int C_DATA_WIDTH      = 128,
    parameter int DUT2VIP_WORDS_NUM = 1
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      capture_valid,
    input  logic [C_DATA_WIDTH*DUT2VIP_WORDS_NUM-1:0] capture_data,
    output logic                                      m_axis_tvalid,
    input  logic                                      m_axis_tready,
    output logic [C_DATA_WIDTH-1:0]                   m_axis_tdata,
    output logic [C_DATA_WIDTH/8-1:0]                 m_axis_tkeep,
    output logic                                      m_axis_tlast,
    output logic [15:0]                               drop_count,
    output logic                                      overflow,
    output logic [1:0]                                fsm_state
);

    localparam int          TOTAL_W  = C_DATA_WIDTH * DUT2VIP_WORDS_NUM;
    localparam logic [15:0] LAST_IDX = 16'(DUT2VIP_WORDS_NUM - 1);
`ifdef AXIS_VIP_PACKER_CHECKSUM_EN
    localparam logic CS_FLAG = 1'b1;
    typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, PAYLOAD = 2'd2, TRAIL = 2'd3} state_t;
`else
    localparam logic CS_FLAG = 1'b0;
    typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, PAYLOAD = 2'd2} state_t;
`endif

    state_t               state;
    logic [15:0]          beat_idx;
    logic [7:0]           seq_cnt;
    logic [TOTAL_W-1:0]   active_data;
    logic [TOTAL_W-1:0]   pend_data;
    logic [7:0]           pend_seq;
    logic                 pend_full;
`ifdef AXIS_VIP_PACKER_CHECKSUM_EN
    logic [C_DATA_WIDTH-1:0] csum;
`endif

    logic        hs;
    logic        final_hs;
    logic        start_frame;
    logic        from_pend;
    logic        cap_to_active;
    logic        cap_to_pend;
    logic        cap_drop;
    logic        go_idle;
    logic [7:0]  hdr_seq;
    logic [15:0] beat_next;

    function automatic logic [C_DATA_WIDTH-1:0] word_of(input logic [TOTAL_W-1:0] data,
                                                        input logic [15:0] idx);
        word_of = C_DATA_WIDTH'(data >> (32'(idx) * C_DATA_WIDTH));
    endfunction

    function automatic logic [C_DATA_WIDTH-1:0] header_of(input logic [7:0] s, input logic [15:0] d);
        logic [C_DATA_WIDTH-1:0] h;
        h        = '0;
        h[7:0]   = 8'hA5;
        h[15:8]  = s;
        h[31:16] = 16'(DUT2VIP_WORDS_NUM);
        h[47:32] = d;
        h[48]    = CS_FLAG;
        return h;
    endfunction

    // Handshake: a beat transfers when tvalid && tready on a rising clk edge; once tvalid is
    // raised, tdata/tkeep/tlast stay frozen and tvalid stays high until that transfer happens.
    always_comb begin
        hs = m_axis_tvalid && m_axis_tready;
`ifdef AXIS_VIP_PACKER_CHECKSUM_EN
        final_hs = hs && (state == TRAIL);
`else
        final_hs = hs && (state == PAYLOAD) && (beat_idx == LAST_IDX);
`endif
        from_pend     = final_hs && pend_full;
        start_frame   = ((state == IDLE) && capture_valid) || (final_hs && (pend_full || capture_valid));
        cap_to_active = capture_valid && ((state == IDLE) || (final_hs && !pend_full));
        cap_to_pend   = capture_valid && !cap_to_active && (!pend_full || final_hs);
        cap_drop      = capture_valid && !cap_to_active && !cap_to_pend;
        go_idle       = final_hs && !start_frame;
        hdr_seq       = from_pend ? pend_seq : seq_cnt;
        beat_next     = beat_idx + 16'd1;
    end

    assign fsm_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            beat_idx      <= '0;
            seq_cnt       <= '0;
            active_data   <= '0;
            pend_data     <= '0;
            pend_seq      <= '0;
            pend_full     <= 1'b0;
            drop_count    <= '0;
            overflow      <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
`ifdef AXIS_VIP_PACKER_CHECKSUM_EN
            csum          <= '0;
`endif
        end else begin
            if (cap_to_active || cap_to_pend) seq_cnt <= seq_cnt + 8'd1;
            if (cap_to_active) active_data <= capture_data;
            else if (from_pend) active_data <= pend_data;
            if (cap_to_pend) begin
                pend_data <= capture_data;
                pend_seq  <= seq_cnt;
                pend_full <= 1'b1;
            end else if (from_pend) begin
                pend_full <= 1'b0;
            end
            if (cap_drop) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            end

            if (start_frame) begin
                state         <= HDR;
                m_axis_tvalid <= 1'b1;
                m_axis_tkeep  <= '1;
                m_axis_tdata  <= header_of(hdr_seq, drop_count);
                m_axis_tlast  <= 1'b0;
            end else if (go_idle) begin
                state         <= IDLE;
                m_axis_tvalid <= 1'b0;
                m_axis_tkeep  <= '0;
                m_axis_tdata  <= '0;
                m_axis_tlast  <= 1'b0;
            end else if (hs) begin
                case (state)
                    HDR: begin
                        state        <= PAYLOAD;
                        beat_idx     <= '0;
                        m_axis_tdata <= word_of(active_data, 16'd0);
                        m_axis_tlast <= !CS_FLAG && (LAST_IDX == 16'd0);
`ifdef AXIS_VIP_PACKER_CHECKSUM_EN
                        csum         <= '0;
`endif
                    end
                    PAYLOAD: begin
`ifdef AXIS_VIP_PACKER_CHECKSUM_EN
                        csum <= csum ^ m_axis_tdata;
                        if (beat_idx == LAST_IDX) begin
                            state        <= TRAIL;
                            m_axis_tdata <= csum ^ m_axis_tdata;
                            m_axis_tlast <= 1'b1;
                        end else begin
                            beat_idx     <= beat_next;
                            m_axis_tdata <= word_of(active_data, beat_next);
                            m_axis_tlast <= 1'b0;
                        end
`else
                        beat_idx     <= beat_next;
                        m_axis_tdata <= word_of(active_data, beat_next);
                        m_axis_tlast <= (beat_next == LAST_IDX);
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_axis_vip_packer.sv
// Directed bench for axis_vip_packer with C_DATA_WIDTH=128, DUT2VIP_WORDS_NUM=2.
module tb_axis_vip_packer;
    localparam int W = 128;
    localparam int N = 2;
`ifdef AXIS_VIP_PACKER_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif
    localparam bit LAST_ON_PAY = !CS;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             capture_valid = 1'b0;
    logic [W*N-1:0]   capture_data = '0;
    logic             m_axis_tvalid;
    logic             m_axis_tready = 1'b0;
    logic [W-1:0]     m_axis_tdata;
    logic [W/8-1:0]   m_axis_tkeep;
    logic             m_axis_tlast;
    logic [15:0]      drop_count;
    logic             overflow;
    logic [1:0]       fsm_state;

    int checks = 0;
    int passed = 0;

    axis_vip_packer #(.C_DATA_WIDTH(W), .DUT2VIP_WORDS_NUM(N)) dut (
        .clk(clk), .reset(reset), .capture_valid(capture_valid), .capture_data(capture_data),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
        .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast), .drop_count(drop_count),
        .overflow(overflow), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] hdr(input logic [7:0] s, input logic [15:0] d);
        logic [W-1:0] h;
        h = '0;
        h[7:0] = 8'hA5;
        h[15:8] = s;
        h[31:16] = 16'(N);
        h[47:32] = d;
        h[48] = CS;
        return h;
    endfunction

    function automatic logic [W*N-1:0] mk(input logic [7:0] b0, input logic [7:0] b1);
        return {{16{b1}}, {16{b0}}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        capture_valid = 1'b0;
        m_axis_tready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata, drop_count, overflow, fsm_state} !== '0)
            $display("FAIL reset_outputs: v=%b l=%b k=%h d=%h drops=%0d ovf=%b st=%0d want all zero",
                     m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata, drop_count, overflow, fsm_state);
        else passed++;
    endtask

    task automatic test_single_frame();
        logic [W*N-1:0] dat;
        apply_reset();
        dat = mk(8'h11, 8'h22);
        m_axis_tready = 1'b1;
        capture_valid = 1'b1;
        capture_data = dat;
        tick();
        capture_valid = 1'b0;
        checks++;
        if ({m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata} !== {1'b1, 1'b0, 16'hFFFF, hdr(8'd0, 16'd0)})
            $display("FAIL single_hdr: v=%b l=%b k=%h d=%h want v=1 l=0 k=ffff d=%h",
                     m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata, hdr(8'd0, 16'd0));
        else passed++;
        for (int b = 0; b < N; b++) begin
            tick();
            checks++;
            if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== {1'b1, LAST_ON_PAY && (b == N-1), dat[b*W +: W]})
                $display("FAIL single_word%0d: v=%b l=%b d=%h want %h", b, m_axis_tvalid, m_axis_tlast,
                         m_axis_tdata, dat[b*W +: W]);
            else passed++;
        end
`ifdef AXIS_VIP_PACKER_CHECKSUM_EN
        tick();
        checks++;
        if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== {1'b1, 1'b1, {16{8'h33}}})
            $display("FAIL single_trailer: v=%b l=%b d=%h want %h", m_axis_tvalid, m_axis_tlast,
                     m_axis_tdata, {16{8'h33}});
        else passed++;
`endif
        tick();
        checks++;
        if ({m_axis_tvalid, m_axis_tlast, m_axis_tkeep} !== '0)
            $display("FAIL single_idle: v=%b l=%b k=%h want 0", m_axis_tvalid, m_axis_tlast, m_axis_tkeep);
        else passed++;
    endtask

`ifdef AXIS_VIP_PACKER_CHECKSUM_EN
    task automatic test_checksum();
        logic [W*N-1:0] dat;
        apply_reset();
        dat = mk(8'h0F, 8'hF0);
        m_axis_tready = 1'b1;
        capture_valid = 1'b1;
        capture_data = dat;
        tick();
        capture_valid = 1'b0;
        checks++;
        if (m_axis_tdata[48] !== 1'b1) $display("FAIL cs_flag: got %b want 1", m_axis_tdata[48]);
        else passed++;
        repeat (N + 1) tick();
        checks++;
        if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== {1'b1, 1'b1, {W{1'b1}}})
            $display("FAIL cs_trailer: v=%b l=%b d=%h want all ones", m_axis_tvalid, m_axis_tlast, m_axis_tdata);
        else passed++;
    endtask
`endif

    task automatic test_backpressure();
        logic [W*N-1:0] dat;
        apply_reset();
        dat = mk(8'h5A, 8'hC3);
        capture_valid = 1'b1;
        capture_data = dat;
        tick();
        capture_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata} !== {1'b1, 1'b0, 16'hFFFF, hdr(8'd0, 16'd0)})
                $display("FAIL bp_hold%0d: v=%b l=%b d=%h want %h", i, m_axis_tvalid, m_axis_tlast,
                         m_axis_tdata, hdr(8'd0, 16'd0));
            else passed++;
            tick();
        end
        m_axis_tready = 1'b1;
        for (int b = 0; b < N; b++) begin
            tick();
            checks++;
            if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== {1'b1, LAST_ON_PAY && (b == N-1), dat[b*W +: W]})
                $display("FAIL bp_word%0d: v=%b l=%b d=%h want %h", b, m_axis_tvalid, m_axis_tlast,
                         m_axis_tdata, dat[b*W +: W]);
            else passed++;
        end
`ifdef AXIS_VIP_PACKER_CHECKSUM_EN
        tick();
`endif
        tick();
        checks++;
        if (m_axis_tvalid !== 1'b0) $display("FAIL bp_done: v=%b want 0", m_axis_tvalid);
        else passed++;
    endtask

    task automatic test_overflow();
        logic [W*N-1:0] d0;
        logic [W*N-1:0] d1;
        apply_reset();
        d0 = mk(8'hA0, 8'hA1);
        d1 = mk(8'hB0, 8'hB1);
        for (int i = 0; i < 4; i++) begin
            capture_valid = 1'b1;
            capture_data = (i == 0) ? d0 : (i == 1) ? d1 : mk(8'hEE, 8'(i));
            tick();
        end
        capture_valid = 1'b0;
        checks++;
        if ({drop_count, overflow, m_axis_tdata} !== {16'd2, 1'b1, hdr(8'd0, 16'd0)})
            $display("FAIL ovf_state: drops=%0d ovf=%b d=%h want drops=2 ovf=1 d=%h",
                     drop_count, overflow, m_axis_tdata, hdr(8'd0, 16'd0));
        else passed++;
        m_axis_tready = 1'b1;
        for (int b = 0; b < N; b++) begin
            tick();
            checks++;
            if ({m_axis_tvalid, m_axis_tdata} !== {1'b1, d0[b*W +: W]})
                $display("FAIL ovf_f0_word%0d: v=%b d=%h want %h", b, m_axis_tvalid, m_axis_tdata, d0[b*W +: W]);
            else passed++;
        end
`ifdef AXIS_VIP_PACKER_CHECKSUM_EN
        tick();
`endif
        tick();
        checks++;
        if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== {1'b1, 1'b0, hdr(8'd1, 16'd2)})
            $display("FAIL ovf_f1_hdr: v=%b l=%b d=%h want %h", m_axis_tvalid, m_axis_tlast,
                     m_axis_tdata, hdr(8'd1, 16'd2));
        else passed++;
        for (int b = 0; b < N; b++) begin
            tick();
            checks++;
            if ({m_axis_tvalid, m_axis_tdata} !== {1'b1, d1[b*W +: W]})
                $display("FAIL ovf_f1_word%0d: v=%b d=%h want %h", b, m_axis_tvalid, m_axis_tdata, d1[b*W +: W]);
            else passed++;
        end
`ifdef AXIS_VIP_PACKER_CHECKSUM_EN
        tick();
`endif
        tick();
        checks++;
        if (m_axis_tvalid !== 1'b0) $display("FAIL ovf_idle: v=%b want 0", m_axis_tvalid);
        else passed++;
    endtask

    task automatic test_simultaneous();
        logic [W*N-1:0] db;
        apply_reset();
        db = mk(8'h61, 8'h62);
        capture_valid = 1'b1;
        capture_data = mk(8'h51, 8'h52);
        tick();
        capture_data = db;
        tick();
        capture_valid = 1'b0;
        m_axis_tready = 1'b1;
        repeat ((CS ? N + 2 : N + 1) - 1) tick();
        checks++;
        if ({m_axis_tvalid, m_axis_tlast} !== 2'b11)
            $display("FAIL sim_final_beat: v=%b l=%b want 1 1", m_axis_tvalid, m_axis_tlast);
        else passed++;
        capture_valid = 1'b1;
        capture_data = mk(8'h71, 8'h72);
        tick();
        capture_valid = 1'b0;
        checks++;
        if ({m_axis_tvalid, m_axis_tdata, drop_count, overflow} !== {1'b1, hdr(8'd1, 16'd0), 16'd0, 1'b0})
            $display("FAIL sim_next_hdr: v=%b d=%h drops=%0d ovf=%b want d=%h drops=0 ovf=0",
                     m_axis_tvalid, m_axis_tdata, drop_count, overflow, hdr(8'd1, 16'd0));
        else passed++;
        tick();
        checks++;
        if (m_axis_tdata !== db[W-1:0]) $display("FAIL sim_b_word0: d=%h want %h", m_axis_tdata, db[W-1:0]);
        else passed++;
        repeat ((CS ? N + 2 : N + 1) - 1) tick();
        checks++;
        if ({m_axis_tvalid, m_axis_tdata} !== {1'b1, hdr(8'd2, 16'd0)})
            $display("FAIL sim_c_hdr: v=%b d=%h want %h", m_axis_tvalid, m_axis_tdata, hdr(8'd2, 16'd0));
        else passed++;
        m_axis_tready = 1'b0;
    endtask

    task automatic test_seq_wrap();
        apply_reset();
        m_axis_tready = 1'b1;
        for (int i = 0; i < 258; i++) begin
            capture_valid = 1'b1;
            capture_data = mk(8'(i), 8'(i + 1));
            tick();
            capture_valid = 1'b0;
            checks++;
            if ({m_axis_tvalid, m_axis_tdata} !== {1'b1, hdr(8'(i), 16'd0)})
                $display("FAIL wrap_hdr%0d: v=%b d=%h want %h", i, m_axis_tvalid, m_axis_tdata, hdr(8'(i), 16'd0));
            else passed++;
            repeat (CS ? N + 2 : N + 1) tick();
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        m_axis_tready = 1'b1;
        capture_valid = 1'b1;
        capture_data = mk(8'h91, 8'h92);
        tick();
        capture_valid = 1'b0;
        tick();
        m_axis_tready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata} !== '0)
            $display("FAIL rst_mid_async: v=%b l=%b k=%h d=%h want 0", m_axis_tvalid, m_axis_tlast,
                     m_axis_tkeep, m_axis_tdata);
        else passed++;
        tick();
        reset = 1'b0;
        capture_valid = 1'b1;
        capture_data = mk(8'hA1, 8'hA2);
        tick();
        capture_valid = 1'b0;
        checks++;
        if ({m_axis_tvalid, m_axis_tdata} !== {1'b1, hdr(8'd0, 16'd0)})
            $display("FAIL rst_mid_seq0: v=%b d=%h want %h", m_axis_tvalid, m_axis_tdata, hdr(8'd0, 16'd0));
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single_frame();
`ifdef AXIS_VIP_PACKER_CHECKSUM_EN
        test_checksum();
`endif
        test_backpressure();
        test_overflow();
        test_simultaneous();
        test_seq_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
